// File: rtl/sdcard_pkg.sv
// Shared definitions for the SD-card sector reader: register map, command word,
// status bit positions and the state encodings of the reader and its APB port.
package sdcard_pkg;

    localparam logic [4:0]  ARG_ADDR             = 5'h04;
    localparam logic [4:0]  CMD_ADDR             = 5'h00;
    localparam logic [4:0]  FIFO_ADDR            = 5'h18;
    localparam logic [31:0] READ_CMD             = 32'h0000_0951;
    localparam int          BUSY_BIT             = 14;
    localparam int          ERR_BIT              = 15;
    localparam int          WORDS                = 128;
    localparam logic [23:0] DEFAULT_POLL_TIMEOUT = 24'd10_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ARG,
        ST_WR_CMD,
        ST_POLL,
        ST_DRAIN,
        ST_FIN
    } reader_state_t;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_t;

    function automatic logic is_last_word(input logic [6:0] cnt);
        return cnt == 7'(WORDS - 1);
    endfunction

endpackage

// File: rtl/sdcard_block_reader_apb_master_port.sv
// Single-transfer APB master: a start pulse launches one SETUP/ACCESS pair and
// done/rdata/err report the result combinationally in the PREADY cycle.
module apb_master_port
    import sdcard_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic        write,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [4:0]  apb_PADDR,
    output logic        apb_PSEL,
    output logic        apb_PENABLE,
    output logic        apb_PWRITE,
    output logic [31:0] apb_PWDATA,
    input  logic [31:0] apb_PRDATA,
    input  logic        apb_PREADY,
    input  logic        apb_PSLVERROR
);

    apb_state_t state, next_state;
    logic [4:0]  paddr_q;
    logic [31:0] pwdata_q;
    logic        pwrite_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= APB_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            APB_IDLE:   if (start) next_state = APB_SETUP;
            APB_SETUP:  next_state = APB_ACCESS;
            APB_ACCESS: if (apb_PREADY) next_state = APB_IDLE;
            default:    next_state = APB_IDLE;
        endcase
    end

    // Address/data/direction are captured once so they stay stable until PREADY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else if (start && state == APB_IDLE) begin
            paddr_q  <= addr;
            pwdata_q <= wdata;
            pwrite_q <= write;
        end
    end

    always_comb begin
        busy        = (state != APB_IDLE);
        apb_PSEL    = (state != APB_IDLE);
        apb_PENABLE = (state == APB_ACCESS);
        apb_PADDR   = paddr_q;
        apb_PWDATA  = pwdata_q;
        apb_PWRITE  = pwrite_q;
        done        = (state == APB_ACCESS) && apb_PREADY;
        rdata       = apb_PRDATA;
        err         = done && apb_PSLVERROR;
    end

endmodule

// File: rtl/sdcard_block_reader.sv
// Sector reader: programs CMD17 into the SD controller over APB, polls for
// completion and streams the 128-word sector out on a valid/ready port.
module sdcard_block_reader
    import sdcard_pkg::*;
#(
    parameter logic [23:0] POLL_TIMEOUT = DEFAULT_POLL_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_lba,
    output logic [4:0]  apb_PADDR,
    output logic        apb_PSEL,
    output logic        apb_PENABLE,
    output logic        apb_PWRITE,
    output logic [31:0] apb_PWDATA,
    input  logic [31:0] apb_PRDATA,
    input  logic        apb_PREADY,
    input  logic        apb_PSLVERROR,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        done,
    output logic        error
);

    reader_state_t state, next_state;
    logic          abort_now;
    logic [31:0]   lba_q;
    logic [6:0]    word_cnt;
    logic [23:0]   tmo_cnt;
    logic          out_valid_q;
    logic [31:0]   out_data_q;
    logic          err_q;
    logic          armed;
    logic          stream_hs;

    logic          m_start, m_write, m_busy, m_done, m_err;
    logic [4:0]    m_addr;
    logic [31:0]   m_wdata, m_rdata;

    apb_master_port u_apb (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (m_start),
        .addr          (m_addr),
        .wdata         (m_wdata),
        .write         (m_write),
        .busy          (m_busy),
        .done          (m_done),
        .rdata         (m_rdata),
        .err           (m_err),
        .apb_PADDR     (apb_PADDR),
        .apb_PSEL      (apb_PSEL),
        .apb_PENABLE   (apb_PENABLE),
        .apb_PWRITE    (apb_PWRITE),
        .apb_PWDATA    (apb_PWDATA),
        .apb_PRDATA    (apb_PRDATA),
        .apb_PREADY    (apb_PREADY),
        .apb_PSLVERROR (apb_PSLVERROR)
    );

    assign stream_hs = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    // Every APB-driven transition happens on the transfer's done cycle, so a
    // state change never orphans a transfer that is still on the bus.
    always_comb begin
        next_state = state;
        abort_now  = 1'b0;
        case (state)
            ST_IDLE:   if (req_valid && req_ready) next_state = ST_WR_ARG;
            ST_WR_ARG: if (m_done) next_state = m_err ? ST_FIN : ST_WR_CMD;
            ST_WR_CMD: if (m_done) next_state = m_err ? ST_FIN : ST_POLL;
            ST_POLL: begin
                if (m_done) begin
                    if (m_err || m_rdata[ERR_BIT])       next_state = ST_FIN;
                    else if (!m_rdata[BUSY_BIT])         next_state = ST_DRAIN;
                    else if (tmo_cnt == POLL_TIMEOUT - 24'd1) next_state = ST_FIN;
                end
            end
            ST_DRAIN: begin
                if (m_done && m_err)                                next_state = ST_FIN;
                else if (stream_hs && is_last_word(word_cnt))       next_state = ST_FIN;
            end
            ST_FIN:    next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
        if (next_state == ST_FIN && !(state == ST_DRAIN && !m_done))
            abort_now = 1'b1;
    end

    always_comb begin
        req_ready = (state == ST_IDLE) && armed;
        done      = (state == ST_FIN);
        error     = (state == ST_FIN) && err_q;
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_last  = out_valid_q && is_last_word(word_cnt);
        m_start   = 1'b0;
        m_addr    = CMD_ADDR;
        m_wdata   = '0;
        m_write   = 1'b0;
        case (state)
            ST_WR_ARG: begin
                m_addr  = ARG_ADDR;
                m_wdata = lba_q;
                m_write = 1'b1;
                m_start = !m_busy;
            end
            ST_WR_CMD: begin
                m_wdata = READ_CMD;
                m_write = 1'b1;
                m_start = !m_busy;
            end
            ST_POLL:  m_start = !m_busy;
            ST_DRAIN: begin
                m_addr  = FIFO_ADDR;
                m_start = !m_busy && !out_valid_q;
            end
            default: ;
        endcase
    end

    // A pending word blocks further FIFO reads, which makes the output register a single-entry skid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed       <= 1'b0;
            lba_q       <= '0;
            word_cnt    <= '0;
            tmo_cnt     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (state == ST_IDLE && req_valid && req_ready) begin
                lba_q    <= req_lba;
                word_cnt <= '0;
                err_q    <= 1'b0;
            end
            if (abort_now)
                err_q <= 1'b1;
            if (state == ST_WR_CMD && next_state == ST_POLL)
                tmo_cnt <= '0;
            else if (state == ST_POLL && m_done && next_state == ST_POLL)
                tmo_cnt <= tmo_cnt + 24'd1;
            if (state == ST_DRAIN && m_done && !m_err) begin
                out_valid_q <= 1'b1;
                out_data_q  <= m_rdata;
            end else if (stream_hs) begin
                out_valid_q <= 1'b0;
                word_cnt    <= word_cnt + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdcard_block_reader.sv
// Directed bench: reactive APB slave model with one wait state, stream sink
// with a scripted stall, and hand-checked expectations per scenario.
module tb_sdcard_block_reader;
    import sdcard_pkg::*;

    localparam logic [23:0] POLL_TO = 24'd20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_lba = '0;
    logic [4:0]  apb_PADDR;
    logic        apb_PSEL, apb_PENABLE, apb_PWRITE;
    logic [31:0] apb_PWDATA;
    logic [31:0] apb_PRDATA = '0;
    logic        apb_PREADY = 1'b0;
    logic        apb_PSLVERROR = 1'b0;
    logic        out_valid, out_last, done, error;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;

    sdcard_block_reader #(.POLL_TIMEOUT(POLL_TO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_lba       (req_lba),
        .apb_PADDR     (apb_PADDR),
        .apb_PSEL      (apb_PSEL),
        .apb_PENABLE   (apb_PENABLE),
        .apb_PWRITE    (apb_PWRITE),
        .apb_PWDATA    (apb_PWDATA),
        .apb_PRDATA    (apb_PRDATA),
        .apb_PREADY    (apb_PREADY),
        .apb_PSLVERROR (apb_PSLVERROR),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int busy_polls = 0;
    bit err_first = 1'b0;
    bit busy_stuck = 1'b0;
    int slverr_at = -1;

    logic [4:0]  log_addr[$];
    bit          log_write[$];
    logic [31:0] log_data[$];
    int wait_cnt = 0;
    int polls_in_req = 0;
    int fifo_in_req = 0;

    logic [31:0] rx_data[$];
    int rx_cnt = 0;
    int valid_cycles = 0;
    int last_cnt = 0;
    int last_idx = -1;
    int stall_at = -1;
    int stall_used = 0;
    int stall_data_bad = 0;
    int stall_psel_bad = 0;

    function automatic logic [31:0] fifoWord(input int k);
        return 32'hA5C3_0000 + 32'(k) * 32'h0000_0101;
    endfunction

    function automatic int countReads(input int base, input logic [4:0] addr);
        int n = 0;
        for (int i = base; i < log_addr.size(); i++)
            if (log_addr[i] == addr && !log_write[i]) n++;
        return n;
    endfunction

    // Slave answers every ACCESS after one wait state; a CMD write starts a new request.
    always @(negedge clk) begin
        apb_PREADY    = 1'b0;
        apb_PSLVERROR = 1'b0;
        if (apb_PSEL && apb_PENABLE) begin
            if (wait_cnt >= 1) begin
                wait_cnt   = 0;
                apb_PREADY = 1'b1;
                log_addr.push_back(apb_PADDR);
                log_write.push_back(apb_PWRITE);
                log_data.push_back(apb_PWDATA);
                if (apb_PWRITE) begin
                    apb_PRDATA = '0;
                    if (apb_PADDR == CMD_ADDR) begin
                        polls_in_req = 0;
                        fifo_in_req  = 0;
                    end
                end else if (apb_PADDR == CMD_ADDR) begin
                    if (err_first)                               apb_PRDATA = 32'h0000_8000;
                    else if (busy_stuck || polls_in_req < busy_polls) apb_PRDATA = 32'h0000_4000;
                    else                                         apb_PRDATA = 32'h0000_0000;
                    polls_in_req++;
                end else begin
                    apb_PRDATA    = fifoWord(fifo_in_req);
                    apb_PSLVERROR = (fifo_in_req == slverr_at);
                    fifo_in_req++;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            out_ready = 1'b1;
        end else if (out_valid) begin
            valid_cycles++;
            if (rx_cnt == stall_at && stall_used < 5) begin
                out_ready = 1'b0;
                if (out_data !== fifoWord(7)) stall_data_bad++;
                if (apb_PSEL !== 1'b0)        stall_psel_bad++;
                stall_used++;
            end else begin
                out_ready = 1'b1;
                rx_data.push_back(out_data);
                if (out_last) begin
                    last_cnt++;
                    last_idx = rx_cnt;
                end
                rx_cnt++;
            end
        end else begin
            out_ready = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic sendRequest(input logic [31:0] lba);
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        if (!req_ready) checkOutput("req_ready_timeout", 32'(req_ready), 32'd1);
        req_lba   = lba;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitDone(output bit got_done, output bit got_err);
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done) begin
                got_done = 1'b1;
                got_err  = error;
                break;
            end
            @(negedge clk);
        end
        if (!got_done) checkOutput("done_timeout", 32'(done), 32'd1);
        @(negedge clk);
        checkOutput("done_pulse", 32'(done), 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] lba, output bit got_done, output bit got_err);
        sendRequest(lba);
        waitDone(got_done, got_err);
    endtask

    task automatic verifyStream(input string tag, input int base, input int n);
        for (int i = 0; i < n && base + i < rx_data.size(); i++)
            checkOutput(tag, rx_data[base + i], fifoWord(i));
    endtask

    initial begin
        bit gd, ge;
        int lb, rb, vb, lc;

        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_psel", 32'(apb_PSEL), 32'd0);
        checkOutput("rst_penable", 32'(apb_PENABLE), 32'd0);
        checkOutput("rst_pwrite", 32'(apb_PWRITE), 32'd0);
        checkOutput("rst_paddr", 32'(apb_PADDR), 32'd0);
        checkOutput("rst_pwdata", apb_PWDATA, 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        reset_n = 1'b1;

        // Nominal sector with three busy polls and a 5-cycle stall on word 7.
        busy_polls = 3;
        lb = log_addr.size(); rb = rx_cnt; lc = last_cnt;
        stall_at = rb + 7;
        applyStimulus(32'h0000_1234, gd, ge);
        checkOutput("t1_done", 32'(gd), 32'd1);
        checkOutput("t1_error", 32'(ge), 32'd0);
        checkOutput("t1_log_len", 32'(log_addr.size() - lb), 32'd134);
        checkOutput("t1_arg_addr", 32'(log_addr[lb]), 32'(ARG_ADDR));
        checkOutput("t1_arg_write", 32'(log_write[lb]), 32'd1);
        checkOutput("t1_arg_data", log_data[lb], 32'h0000_1234);
        checkOutput("t1_cmd_addr", 32'(log_addr[lb + 1]), 32'(CMD_ADDR));
        checkOutput("t1_cmd_write", 32'(log_write[lb + 1]), 32'd1);
        checkOutput("t1_cmd_data", log_data[lb + 1], 32'h0000_0951);
        checkOutput("t1_polls", 32'(countReads(lb, CMD_ADDR)), 32'd4);
        checkOutput("t1_fifo_reads", 32'(countReads(lb, FIFO_ADDR)), 32'd128);
        checkOutput("t1_words", 32'(rx_cnt - rb), 32'd128);
        checkOutput("t1_last_cnt", 32'(last_cnt - lc), 32'd1);
        checkOutput("t1_last_idx", 32'(last_idx - rb), 32'd127);
        checkOutput("t2_stall_len", 32'(stall_used), 32'd5);
        checkOutput("t2_stall_data", 32'(stall_data_bad), 32'd0);
        checkOutput("t2_stall_psel", 32'(stall_psel_bad), 32'd0);
        verifyStream("t1_word", rb, 128);
        busy_polls = 0;

        // Error bit on the first poll.
        err_first = 1'b1;
        lb = log_addr.size(); vb = valid_cycles;
        applyStimulus(32'h0000_0042, gd, ge);
        checkOutput("t3_done", 32'(gd), 32'd1);
        checkOutput("t3_error", 32'(ge), 32'd1);
        checkOutput("t3_log_len", 32'(log_addr.size() - lb), 32'd3);
        checkOutput("t3_fifo_reads", 32'(countReads(lb, FIFO_ADDR)), 32'd0);
        checkOutput("t3_valid_cycles", 32'(valid_cycles - vb), 32'd0);
        err_first = 1'b0;

        // Slave error on the 50th FIFO read.
        slverr_at = 49;
        lb = log_addr.size(); rb = rx_cnt; lc = last_cnt;
        applyStimulus(32'h0000_0777, gd, ge);
        checkOutput("t4_done", 32'(gd), 32'd1);
        checkOutput("t4_error", 32'(ge), 32'd1);
        checkOutput("t4_fifo_reads", 32'(countReads(lb, FIFO_ADDR)), 32'd50);
        checkOutput("t4_words", 32'(rx_cnt - rb), 32'd49);
        checkOutput("t4_last_cnt", 32'(last_cnt - lc), 32'd0);
        checkOutput("t4_req_ready", 32'(req_ready), 32'd1);
        verifyStream("t4_word", rb, 49);
        slverr_at = -1;

        // Busy never clears: exactly POLL_TO polls, then abort.
        busy_stuck = 1'b1;
        lb = log_addr.size();
        applyStimulus(32'h0000_0099, gd, ge);
        checkOutput("t5_done", 32'(gd), 32'd1);
        checkOutput("t5_error", 32'(ge), 32'd1);
        checkOutput("t5_polls", 32'(countReads(lb, CMD_ADDR)), 32'(POLL_TO));
        checkOutput("t5_fifo_reads", 32'(countReads(lb, FIFO_ADDR)), 32'd0);
        busy_stuck = 1'b0;

        // Reset in the middle of the drain, then a clean full sector.
        rb = rx_cnt;
        sendRequest(32'h0000_0abc);
        for (int i = 0; i < 3000 && rx_cnt < rb + 60; i++) @(negedge clk);
        checkOutput("t6_reached_word60", 32'(rx_cnt >= rb + 60), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_psel", 32'(apb_PSEL), 32'd0);
        checkOutput("t6_rst_penable", 32'(apb_PENABLE), 32'd0);
        checkOutput("t6_rst_paddr", 32'(apb_PADDR), 32'd0);
        checkOutput("t6_rst_pwrite", 32'(apb_PWRITE), 32'd0);
        checkOutput("t6_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_rst_out_data", out_data, 32'd0);
        checkOutput("t6_rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("t6_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rb = rx_cnt; lc = last_cnt;
        applyStimulus(32'h0000_0abd, gd, ge);
        checkOutput("t6_done", 32'(gd), 32'd1);
        checkOutput("t6_error", 32'(ge), 32'd0);
        checkOutput("t6_words", 32'(rx_cnt - rb), 32'd128);
        checkOutput("t6_last_cnt", 32'(last_cnt - lc), 32'd1);
        checkOutput("t6_last_idx", 32'(last_idx - rb), 32'd127);
        verifyStream("t6_word", rb, 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
